// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO holding ALU results
// {sel, flag, cout, sum, mult} between the ALU stage and its consumers.
// Both sides use valid/ready; in_ready depends only on stored state.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sel,
    input  logic                     in_flag,
    input  logic                     in_cout,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic [WIDTH-1:0]         in_mult,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_sel,
    output logic                     out_flag,
    output logic                     out_cout,
    output logic [WIDTH-1:0]         out_sum,
    output logic [WIDTH-1:0]         out_mult,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              pushed
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned EntryW = 2 * WIDTH + 6;

    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    // Storage is deliberately not reset; only pointers and counters are.
    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic [15:0]       pushed_q;

    logic              push;
    logic              pop;
    logic [EntryW-1:0] in_entry;

    // Handshake decode; ready/valid come from registered state only.
    always_comb begin
        in_ready  = (count_q != FullCount);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~rst;
        pop       = out_valid & out_ready;
        in_entry  = {in_sel, in_flag, in_cout, in_sum, in_mult};
    end

    // Head entry is read straight from the array: no input-to-output path.
    always_comb begin
        {out_sel, out_flag, out_cout, out_sum, out_mult} = mem_q[rd_ptr_q];
        count  = count_q;
        pushed = pushed_q;
    end

    // Write the accepted entry at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Pointers, occupancy and the wrapping push counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pushed_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
                pushed_q <= pushed_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo (DEPTH=4, WIDTH=32): a scoreboard
// queue tracks accepted entries and is compared on every pop, alongside
// directed checks for reset, back-pressure, simultaneous push/pop and wrap.
module tb_alu_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sel;
    logic             in_flag;
    logic             in_cout;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_mult;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sel;
    logic             out_flag;
    logic             out_cout;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_mult;
    logic [2:0]       count;
    logic [15:0]      pushed;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [69:0] sb_q[$];
    logic [15:0] pushed_exp;
    logic        started = 1'b0;

    alu_result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_flag   (in_flag),
        .in_cout   (in_cout),
        .in_sum    (in_sum),
        .in_mult   (in_mult),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_flag  (out_flag),
        .out_cout  (out_cout),
        .out_sum   (out_sum),
        .out_mult  (out_mult),
        .count     (count),
        .pushed    (pushed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic flag, input logic cout,
                         input logic [31:0] sum, input logic [31:0] mult);
        in_valid = 1'b1;
        in_sel   = sel;
        in_flag  = flag;
        in_cout  = cout;
        in_sum   = sum;
        in_mult  = mult;
    endtask

    task automatic drain();
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (count != 0 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("drain_timeout", 72'd1, 72'd0);
        out_ready = 1'b0;
    endtask

    // Scoreboard: at each falling edge compare state to the model, then
    // predict what the coming rising edge will do.
    always @(negedge clk) begin
        if (started) begin
            check("sb_count", 72'(count), 72'(sb_q.size()));
            check("sb_in_ready", 72'(in_ready), 72'(sb_q.size() != DEPTH));
            check("sb_out_valid", 72'(out_valid), 72'(sb_q.size() != 0));
            check("sb_pushed", 72'(pushed), 72'(pushed_exp));
            if (rst) begin
                sb_q.delete();
                pushed_exp = '0;
            end else begin
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    check("sb_pop_entry",
                          72'({out_sel, out_flag, out_cout, out_sum, out_mult}),
                          72'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    sb_q.push_back({in_sel, in_flag, in_cout, in_sum, in_mult});
                    pushed_exp = pushed_exp + 16'd1;
                end
            end
        end
    end

    initial begin
        int i;
        int cyc;
        logic acc;

        // Reset with in_valid high: must not be accepted.
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(4'hA, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
        tick();
        check("rst_count", 72'(count), 72'd0);
        check("rst_pushed", 72'(pushed), 72'd0);
        check("rst_in_ready", 72'(in_ready), 72'd1);
        check("rst_out_valid", 72'(out_valid), 72'd0);
        pushed_exp = '0;
        started    = 1'b1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        tick();
        check("idle_count", 72'(count), 72'd0);

        // Single result with the consumer stalled.
        drive(4'd3, 1'b0, 1'b1, 32'h5, 32'h6);
        tick();
        in_valid = 1'b0;
        check("single_valid", 72'(out_valid), 72'd1);
        check("single_entry", 72'({out_sel, out_flag, out_cout, out_sum, out_mult}),
              72'({4'd3, 1'b0, 1'b1, 32'h5, 32'h6}));
        check("single_count", 72'(count), 72'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_pop_count", 72'(count), 72'd0);
        check("single_pop_valid", 72'(out_valid), 72'd0);

        // Fill to DEPTH, then hold a fifth result under back-pressure.
        for (int k = 1; k <= 4; k++) begin
            drive(4'(k), 1'b0, 1'b0, 32'(k), 32'(k * 7));
            tick();
        end
        check("full_count", 72'(count), 72'd4);
        check("full_in_ready", 72'(in_ready), 72'd0);
        drive(4'd5, 1'b1, 1'b0, 32'd5, 32'd35);
        tick();
        tick();
        check("held_count", 72'(count), 72'd4);
        check("held_pushed", 72'(pushed), 72'd5);
        check("head_is_1", 72'(out_sum), 72'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_pop_count", 72'(count), 72'd3);
        check("after_pop_in_ready", 72'(in_ready), 72'd1);
        tick();
        in_valid = 1'b0;
        check("fifth_count", 72'(count), 72'd4);
        check("fifth_pushed", 72'(pushed), 72'd6);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("drain_order", 72'(out_sum), 72'(k));
            tick();
        end
        out_ready = 1'b0;
        check("drained_count", 72'(count), 72'd0);

        // Simultaneous push and pop at count=2.
        drive(4'd0, 1'b0, 1'b0, 32'h10, 32'h100);
        tick();
        drive(4'd1, 1'b0, 1'b0, 32'h11, 32'h110);
        tick();
        check("pp_pre_count", 72'(count), 72'd2);
        drive(4'd2, 1'b1, 1'b1, 32'h12, 32'h120);
        out_ready = 1'b1;
        check("pp_head_before", 72'(out_sum), 72'h10);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_count", 72'(count), 72'd2);
        check("pp_pushed", 72'(pushed), 72'd9);
        check("pp_head_after", 72'(out_sum), 72'h11);
        drain();

        // Fresh reset, then stream 10 results across the pointer wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i   = 0;
        cyc = 0;
        while (i < 10 && cyc < 200) begin
            drive(4'(i), i[0], i[1], 32'(i), 32'(i * i));
            out_ready = (cyc % 2 == 0);
            acc = in_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        if (cyc >= 200) check("stream_timeout", 72'd1, 72'd0);
        drain();
        check("stream_pushed", 72'(pushed), 72'd10);

        // Reset mid-operation with three entries stored.
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 1'b1, 1'b1, 32'(k + 100), 32'(k));
            tick();
        end
        in_valid = 1'b0;
        check("mid_pre_count", 72'(count), 72'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 72'(count), 72'd0);
        check("mid_rst_valid", 72'(out_valid), 72'd0);
        check("mid_rst_pushed", 72'(pushed), 72'd0);
        drive(4'd9, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        in_valid = 1'b0;
        check("mid_new_valid", 72'(out_valid), 72'd1);
        check("mid_new_head", 72'(out_sum), 72'hDEAD_BEEF);
        check("mid_new_count", 72'(count), 72'd1);
        drain();
        tick();
        started = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
